// File: rtl/lv_fsm_pkg.sv
// Shared types for the LV-die chip-mode controller.
// Holds the state encoding and its width.
package lv_fsm_pkg;

  localparam int CTRL_FSM_ST_W = 4;

  typedef enum logic [CTRL_FSM_ST_W-1:0] {
    ST_PWR_DWN  = 4'd0,
    ST_WAIT     = 4'd1,
    ST_TEST     = 4'd2,
    ST_NML      = 4'd3,
    ST_FAILSAFE = 4'd4,
    ST_FAULT    = 4'd5,
    ST_CFG      = 4'd6,
    ST_RST      = 4'd7,
    ST_BIST     = 4'd8
  } ctrl_st_e;

endpackage

// File: rtl/lv_err_qual.sv
// One error source: debounce counter, qualified level and sticky flag.
// Ports: clk, rst_n, raw, mask, clr, clr_all, dbnc in; qual, sticky out.
module lv_err_qual #(
  parameter int DBNC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              raw,
  input  logic              mask,
  input  logic              clr,
  input  logic              clr_all,
  input  logic [DBNC_W-1:0] dbnc,
  output logic              qual,
  output logic              sticky
);

  logic [DBNC_W-1:0] cnt;
  logic              qual_set;

  assign qual_set = raw & ~mask & ~qual & (cnt >= dbnc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      qual   <= 1'b0;
      sticky <= 1'b0;
    end else begin
      if (!raw || mask) begin
        cnt  <= '0;
        qual <= 1'b0;
      end else if (cnt >= dbnc) begin
        qual <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // A fresh qualification always wins over any clear.
      if (qual_set) begin
        sticky <= 1'b1;
      end else if (clr_all) begin
        sticky <= 1'b0;
      end else if (clr && !qual) begin
        sticky <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lv_err_fsm_ctrl.sv
// LV-die chip-mode FSM with error qualification, recovery and efuse load.
// Ports: mode/efuse/error inputs in; block enables, intb, state, sticky out.
module lv_err_fsm_ctrl
  import lv_fsm_pkg::*;
#(
  parameter int ERR_NUM = 16,
  parameter int DBNC_W  = 4,
  parameter int RCV_W   = 8,
  parameter int TMO_W   = 10
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pwr_on,
  input  logic               i_io_test_mode,
  input  logic               i_io_fsenb_n,
  input  logic [ERR_NUM-1:0] i_err_raw,
  input  logic [ERR_NUM-1:0] i_reg_err_mask,
  input  logic [ERR_NUM-1:0] i_reg_err_crit,
  input  logic [ERR_NUM-1:0] i_reg_err_clr,
  input  logic [DBNC_W-1:0]  i_reg_dbnc_cyc,
  input  logic [RCV_W-1:0]   i_reg_rcv_cyc,
  input  logic               i_reg_auto_rcv_en,
  input  logic               i_reg_nml_en,
  input  logic               i_reg_cfg_en,
  input  logic               i_reg_bist_en,
  input  logic               i_reg_rst_en,
  input  logic               i_efuse_vld,
  input  logic               i_efuse_load_done,
  output logic               o_efuse_load_req,
  output logic               o_efuse_tmo_err,
  output logic               o_pwm_en,
  output logic               o_fsc_en,
  output logic               o_spi_en,
  output logic               o_bist_en,
  output logic               o_intb_n,
  output logic [CTRL_FSM_ST_W-1:0] o_cur_st,
  output logic [ERR_NUM-1:0] o_err_sticky
);

  localparam logic [TMO_W-1:0] TMO_MAX  = '1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - 1'b1;

  ctrl_st_e cur_st, nxt_st, run_st;

  logic [ERR_NUM-1:0] qual;
  logic               crit_err, any_err, clr_all;
  logic [RCV_W-1:0]   rcv_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               req_set, tmo_fire;

  assign crit_err = |(qual & i_reg_err_crit);
  assign any_err  = |qual;
  assign clr_all  = (nxt_st == ST_RST) && (cur_st != ST_RST);
  assign run_st   = i_io_fsenb_n ? ST_NML : ST_FAILSAFE;
  assign o_cur_st = cur_st;

  for (genvar g = 0; g < ERR_NUM; g++) begin : g_qual
    lv_err_qual #(.DBNC_W(DBNC_W)) u_qual (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .raw     (i_err_raw[g]),
      .mask    (i_reg_err_mask[g]),
      .clr     (i_reg_err_clr[g]),
      .clr_all (clr_all),
      .dbnc    (i_reg_dbnc_cyc),
      .qual    (qual[g]),
      .sticky  (o_err_sticky[g])
    );
  end

  // Timeout fires on the edge the counter would reach all-ones;
  // a load_done on that same edge counts as success.
  assign tmo_fire = o_efuse_load_req & ~i_efuse_load_done &
                    (tmo_cnt == TMO_LAST);
  assign req_set  = (cur_st == ST_WAIT) & ~i_io_test_mode &
                    ~i_efuse_vld & ~o_efuse_load_req &
                    ~o_efuse_tmo_err;

  always_comb begin
    nxt_st = cur_st;
    if (!i_pwr_on) begin
      nxt_st = ST_PWR_DWN;
    end else begin
      case (cur_st)
        ST_PWR_DWN: nxt_st = ST_WAIT;
        ST_WAIT: begin
          if (i_io_test_mode ||
              (i_efuse_load_done && !i_efuse_vld) || tmo_fire)
            nxt_st = ST_TEST;
          else if (i_reg_nml_en && i_efuse_vld && !crit_err)
            nxt_st = run_st;
        end
        ST_TEST: begin
          if (!i_io_test_mode && i_efuse_vld) nxt_st = ST_WAIT;
        end
        ST_NML: begin
          if (i_reg_cfg_en)       nxt_st = ST_CFG;
          else if (crit_err)      nxt_st = ST_FAULT;
          else if (!i_io_fsenb_n) nxt_st = ST_FAILSAFE;
          else if (any_err)       nxt_st = ST_FAULT;
        end
        ST_FAILSAFE: begin
          if (crit_err)          nxt_st = ST_FAULT;
          else if (i_io_fsenb_n) nxt_st = ST_NML;
        end
        ST_FAULT: begin
          if (i_reg_cfg_en)
            nxt_st = ST_CFG;
          else if (i_reg_auto_rcv_en && rcv_cnt == i_reg_rcv_cyc)
            nxt_st = run_st;
        end
        ST_CFG: begin
          if (i_reg_rst_en)                   nxt_st = ST_RST;
          else if (i_reg_bist_en && !crit_err) nxt_st = ST_BIST;
          else if (!i_reg_cfg_en && any_err)  nxt_st = ST_FAULT;
          else if (!i_reg_cfg_en)             nxt_st = run_st;
        end
        ST_RST: begin
          if (!i_reg_rst_en) nxt_st = ST_WAIT;
        end
        ST_BIST: begin
          if (!i_reg_bist_en) nxt_st = ST_CFG;
        end
        default: nxt_st = ST_PWR_DWN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cur_st    <= ST_PWR_DWN;
      o_pwm_en  <= 1'b0;
      o_fsc_en  <= 1'b0;
      o_spi_en  <= 1'b0;
      o_bist_en <= 1'b0;
      o_intb_n  <= 1'b1;
    end else begin
      cur_st    <= nxt_st;
      o_pwm_en  <= (nxt_st == ST_NML) ||
                   ((nxt_st == ST_FAULT) && !crit_err);
      o_fsc_en  <= (nxt_st == ST_FAILSAFE);
      o_spi_en  <= (nxt_st != ST_PWR_DWN);
      o_bist_en <= (nxt_st == ST_BIST);
      o_intb_n  <= !((nxt_st == ST_PWR_DWN) || (nxt_st == ST_WAIT) ||
                     (nxt_st == ST_FAULT) || (nxt_st == ST_RST) ||
                     ((nxt_st == ST_CFG) && any_err));
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rcv_cnt <= '0;
    end else if (cur_st != ST_FAULT || any_err) begin
      rcv_cnt <= '0;
    end else if (rcv_cnt < i_reg_rcv_cyc) begin
      rcv_cnt <= rcv_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_efuse_load_req <= 1'b0;
      o_efuse_tmo_err  <= 1'b0;
      tmo_cnt          <= '0;
    end else begin
      if (req_set)
        o_efuse_load_req <= 1'b1;
      else if (i_efuse_load_done || tmo_fire)
        o_efuse_load_req <= 1'b0;
      tmo_cnt <= o_efuse_load_req ? tmo_cnt + 1'b1 : '0;
      if (cur_st == ST_PWR_DWN || cur_st == ST_RST)
        o_efuse_tmo_err <= 1'b0;
      else if (tmo_fire)
        o_efuse_tmo_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lv_err_fsm_ctrl.sv
// Directed bench for lv_err_fsm_ctrl.
// Walks power-up, debounce, recovery, priority and efuse timeout.
module tb_lv_err_fsm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, pwr_on, test_mode, fsenb_n;
  logic [15:0] raw, mask, crit, clr;
  logic [3:0]  dbnc;
  logic [7:0]  rcv;
  logic        auto_rcv, nml_en, cfg_en, bist_en, rst_en;
  logic        efuse_vld, load_done;
  logic        req, tmo, pwm, fsc, spi, bist, intb;
  logic [3:0]  st;
  logic [15:0] sticky;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  lv_err_fsm_ctrl dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_pwr_on          (pwr_on),
    .i_io_test_mode    (test_mode),
    .i_io_fsenb_n      (fsenb_n),
    .i_err_raw         (raw),
    .i_reg_err_mask    (mask),
    .i_reg_err_crit    (crit),
    .i_reg_err_clr     (clr),
    .i_reg_dbnc_cyc    (dbnc),
    .i_reg_rcv_cyc     (rcv),
    .i_reg_auto_rcv_en (auto_rcv),
    .i_reg_nml_en      (nml_en),
    .i_reg_cfg_en      (cfg_en),
    .i_reg_bist_en     (bist_en),
    .i_reg_rst_en      (rst_en),
    .i_efuse_vld       (efuse_vld),
    .i_efuse_load_done (load_done),
    .o_efuse_load_req  (req),
    .o_efuse_tmo_err   (tmo),
    .o_pwm_en          (pwm),
    .o_fsc_en          (fsc),
    .o_spi_en          (spi),
    .o_bist_en         (bist),
    .o_intb_n          (intb),
    .o_cur_st          (st),
    .o_err_sticky      (sticky)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; pwr_on = 1'b0; test_mode = 1'b0; fsenb_n = 1'b1;
    raw = '0; mask = '0; crit = 16'h0004; clr = '0;
    dbnc = 4'd3; rcv = 8'd10;
    auto_rcv = 1'b0; nml_en = 1'b0; cfg_en = 1'b0;
    bist_en = 1'b0; rst_en = 1'b0;
    efuse_vld = 1'b0; load_done = 1'b0;

    step(2);
    chk("rst_st", 32'(st), 32'd0);
    chk("rst_pwm", 32'(pwm), 32'd0);
    chk("rst_fsc", 32'(fsc), 32'd0);
    chk("rst_spi", 32'(spi), 32'd0);
    chk("rst_bist", 32'(bist), 32'd0);
    chk("rst_intb", 32'(intb), 32'd1);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_tmo", 32'(tmo), 32'd0);
    chk("rst_sticky", 32'(sticky), 32'd0);

    // Power-up and efuse load.
    pwr_on = 1'b1;
    step(1);
    rst_n = 1'b1;
    chk("held_rst_st", 32'(st), 32'd0);
    step(1);
    chk("pu_wait", 32'(st), 32'd1);
    chk("pu_spi", 32'(spi), 32'd1);
    chk("pu_intb", 32'(intb), 32'd0);
    step(1);
    chk("pu_req_hi", 32'(req), 32'd1);
    step(4);
    chk("pu_req_hold", 32'(req), 32'd1);
    load_done = 1'b1; efuse_vld = 1'b1;
    step(1);
    load_done = 1'b0;
    chk("pu_req_lo", 32'(req), 32'd0);
    chk("pu_still_wait", 32'(st), 32'd1);
    nml_en = 1'b1;
    step(1);
    chk("pu_nml", 32'(st), 32'd3);
    chk("pu_pwm", 32'(pwm), 32'd1);
    chk("pu_intb_nml", 32'(intb), 32'd1);

    // Debounce: three high cycles do not qualify with dbnc=3.
    raw[2] = 1'b1;
    step(3);
    raw[2] = 1'b0;
    step(2);
    chk("dbnc_short_st", 32'(st), 32'd3);
    chk("dbnc_short_sticky", 32'(sticky), 32'd0);
    raw[2] = 1'b1;
    step(4);
    chk("dbnc_qual_sticky", 32'(sticky), 32'h4);
    chk("dbnc_qual_st", 32'(st), 32'd3);
    step(1);
    chk("crit_fault_st", 32'(st), 32'd5);
    chk("crit_fault_pwm", 32'(pwm), 32'd0);
    chk("crit_fault_intb", 32'(intb), 32'd0);

    // Sticky clear blocked while qualified, honoured after.
    clr[2] = 1'b1;
    step(1);
    clr[2] = 1'b0;
    chk("clr_blocked", 32'(sticky), 32'h4);
    raw[2] = 1'b0;
    step(1);
    clr[2] = 1'b1;
    step(1);
    clr[2] = 1'b0;
    chk("clr_done", 32'(sticky), 32'h0);
    cfg_en = 1'b1;
    step(1);
    chk("fault_cfg", 32'(st), 32'd6);
    chk("cfg_intb_clean", 32'(intb), 32'd1);
    cfg_en = 1'b0;
    step(1);
    chk("cfg_nml", 32'(st), 32'd3);

    // Masked source never qualifies.
    mask[7] = 1'b1; raw[7] = 1'b1;
    step(6);
    chk("mask_sticky", 32'(sticky), 32'h0);
    chk("mask_st", 32'(st), 32'd3);
    raw[7] = 1'b0; mask[7] = 1'b0;

    // Minor error then timed auto-recovery.
    auto_rcv = 1'b1;
    raw[5] = 1'b1;
    step(4);
    chk("minor_sticky", 32'(sticky), 32'h20);
    step(1);
    chk("minor_fault_st", 32'(st), 32'd5);
    chk("minor_fault_pwm", 32'(pwm), 32'd1);
    chk("minor_fault_intb", 32'(intb), 32'd0);
    step(2);
    raw[5] = 1'b0;
    step(1);
    chk("rcv_qual_fall", 32'(st), 32'd5);
    step(10);
    chk("rcv_edge10", 32'(st), 32'd5);
    step(1);
    chk("rcv_edge11", 32'(st), 32'd3);
    chk("rcv_pwm", 32'(pwm), 32'd1);
    auto_rcv = 1'b0;

    // Failsafe pin.
    fsenb_n = 1'b0;
    step(1);
    chk("fs_st", 32'(st), 32'd4);
    chk("fs_fsc", 32'(fsc), 32'd1);
    chk("fs_pwm", 32'(pwm), 32'd0);
    fsenb_n = 1'b1;
    step(1);
    chk("fs_back", 32'(st), 32'd3);
    chk("fs_fsc_lo", 32'(fsc), 32'd0);

    // Power loss in BIST.
    cfg_en = 1'b1;
    step(1);
    chk("pr_cfg", 32'(st), 32'd6);
    bist_en = 1'b1;
    step(1);
    chk("pr_bist", 32'(st), 32'd8);
    chk("pr_bist_en", 32'(bist), 32'd1);
    pwr_on = 1'b0;
    step(1);
    chk("pr_pwrdn", 32'(st), 32'd0);
    chk("pr_spi_lo", 32'(spi), 32'd0);
    chk("pr_bist_lo", 32'(bist), 32'd0);
    pwr_on = 1'b1; bist_en = 1'b0; cfg_en = 1'b0;
    step(1);
    chk("pr_wait", 32'(st), 32'd1);
    step(1);
    chk("pr_nml", 32'(st), 32'd3);

    // rst_en beats bist_en in CFG; RST entry wipes sticky.
    cfg_en = 1'b1;
    step(1);
    chk("pr_cfg2", 32'(st), 32'd6);
    chk("pr_sticky_pre", 32'(sticky), 32'h20);
    rst_en = 1'b1; bist_en = 1'b1;
    step(1);
    chk("pr_rst", 32'(st), 32'd7);
    chk("pr_rst_intb", 32'(intb), 32'd0);
    rst_en = 1'b0; bist_en = 1'b0; cfg_en = 1'b0;
    nml_en = 1'b0; efuse_vld = 1'b0;
    step(1);
    chk("pr_rst_wait", 32'(st), 32'd1);
    chk("pr_sticky_clr", 32'(sticky), 32'h0);

    // Efuse timeout: req held 1023 cycles then TEST.
    step(1);
    chk("tmo_req_set", 32'(req), 32'd1);
    step(1021);
    chk("tmo_req_mid", 32'(req), 32'd1);
    chk("tmo_st_mid", 32'(st), 32'd1);
    step(1);
    chk("tmo_req_last", 32'(req), 32'd1);
    chk("tmo_err_last", 32'(tmo), 32'd0);
    step(1);
    chk("tmo_req_lo", 32'(req), 32'd0);
    chk("tmo_err", 32'(tmo), 32'd1);
    chk("tmo_test", 32'(st), 32'd2);

    // Reset mid-operation.
    rst_n = 1'b0;
    step(1);
    chk("mid_rst_st", 32'(st), 32'd0);
    chk("mid_rst_tmo", 32'(tmo), 32'd0);
    chk("mid_rst_spi", 32'(spi), 32'd0);
    rst_n = 1'b1;
    step(1);
    chk("re_wait", 32'(st), 32'd1);
    step(1);
    chk("re_req", 32'(req), 32'd1);

    // load_done on the timeout edge counts as done.
    step(1022);
    load_done = 1'b1; efuse_vld = 1'b1;
    step(1);
    load_done = 1'b0;
    chk("race_req", 32'(req), 32'd0);
    chk("race_tmo", 32'(tmo), 32'd0);
    chk("race_st", 32'(st), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
